// File: rtl/fan_pkg.sv
// Shared constants for the FAN adder node: default line geometry, ctrl code layout,
// direction codes and the ctrl codes written onto a merged result line.
package fan_pkg;

    localparam int unsigned FAN_DW_DATA = 8;
    localparam int unsigned FAN_DW_ROW  = 4;
    localparam int unsigned FAN_DW_CTRL = 4;

    // Result ctrl codes are written as {V, K, DIR[1:0]} and spread onto the ctrl field.
    localparam int unsigned CODE_W = 4;
    localparam int unsigned CODE_V = 3;
    localparam int unsigned CODE_K = 2;

    typedef enum logic [1:0] {
        DIR_NONE  = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_RIGHT = 2'b10,
        DIR_BOTH  = 2'b11
    } dir_e;

    localparam logic [CODE_W-1:0] CTRL_COMPLETE  = 4'b0111;
    localparam logic [CODE_W-1:0] CTRL_FWD_RIGHT = 4'b1001;
    localparam logic [CODE_W-1:0] CTRL_FWD_LEFT  = 4'b1010;
    localparam logic [CODE_W-1:0] CTRL_PARTIAL   = 4'b1000;

endpackage

// File: rtl/fan_skid_fifo.sv
// Two-entry valid/ready buffer; in_ready depends only on the registered fill count.
module fan_skid_fifo #(
    parameter int unsigned WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out       = out_valid ? mem[rd_ptr] : '0;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Storage needs no reset: out is masked to zero whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in;
    end

endmodule

// File: rtl/fan_adder_node_pipe.sv
// FAN adder node: merges the valid left-half and right-half lines on matching row tags,
// then buffers the beat in a 2-entry FIFO. Define FAN_ADDER_SAT_EN for a saturating add.
module fan_adder_node_pipe
    import fan_pkg::*;
#(
    parameter int unsigned DW_DATA  = FAN_DW_DATA,
    parameter int unsigned DW_ROW   = FAN_DW_ROW,
    parameter int unsigned DW_CTRL  = FAN_DW_CTRL,
    parameter int unsigned NUM_IN   = 8,
    parameter int unsigned SYMMETRY = 0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [NUM_IN*(DW_DATA+DW_ROW+DW_CTRL)-1:0]  in,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [NUM_IN*(DW_DATA+DW_ROW+DW_CTRL)-1:0]  out,
    output logic [CNT_W-1:0]                            add_cnt,
    output logic                                        err
);

    localparam int unsigned DW_LINE   = DW_DATA + DW_ROW + DW_CTRL;
    localparam int unsigned W         = NUM_IN * DW_LINE;
    localparam int unsigned HALF      = NUM_IN / 2;
    localparam int unsigned OUT_LEFT  = HALF - 1;
    localparam int unsigned OUT_RIGHT = HALF;
    localparam int unsigned OFF_ROW   = DW_DATA;
    localparam int unsigned OFF_CTRL  = DW_DATA + DW_ROW;
    localparam int unsigned OFF_V     = OFF_CTRL + DW_CTRL - 1;
    localparam int unsigned OFF_K     = OFF_CTRL + DW_CTRL - 2;

    function automatic logic [DW_CTRL-1:0] make_ctrl(input logic [CODE_W-1:0] code);
        logic [DW_CTRL-1:0] c;
        c            = '0;
        c[DW_CTRL-1] = code[CODE_V];
        c[DW_CTRL-2] = code[CODE_K];
        c[1:0]       = code[1:0];
        return c;
    endfunction

    logic               lane_v;
    logic               seen_l, seen_r, multi_l, multi_r;
    logic [DW_DATA-1:0] l_data, r_data, s_data;
    logic [DW_ROW-1:0]  l_row, r_row;
    logic [1:0]         l_dir, r_dir;
    logic               is_add;
    logic [CODE_W-1:0]  res_code;
    logic               res_on_right;
    logic [DW_LINE-1:0] res_line;
    logic [W-1:0]       merged;
    logic               fifo_in_ready;
    logic               accept;

    // Operands are the OR of V-masked lanes per half, so a multi-hot half still yields a value.
    always_comb begin
        lane_v  = 1'b0;
        seen_l  = 1'b0;
        seen_r  = 1'b0;
        multi_l = 1'b0;
        multi_r = 1'b0;
        l_data  = '0;
        r_data  = '0;
        l_row   = '0;
        r_row   = '0;
        l_dir   = '0;
        r_dir   = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            lane_v = in[i*DW_LINE + OFF_V];
            if (i < HALF) begin
                multi_l = multi_l | (seen_l & lane_v);
                seen_l  = seen_l | lane_v;
                if (lane_v) begin
                    l_data = l_data | in[i*DW_LINE +: DW_DATA];
                    l_row  = l_row  | in[i*DW_LINE + OFF_ROW +: DW_ROW];
                    l_dir  = l_dir  | in[i*DW_LINE + OFF_CTRL +: 2];
                end
            end else begin
                multi_r = multi_r | (seen_r & lane_v);
                seen_r  = seen_r | lane_v;
                if (lane_v) begin
                    r_data = r_data | in[i*DW_LINE +: DW_DATA];
                    r_row  = r_row  | in[i*DW_LINE + OFF_ROW +: DW_ROW];
                    r_dir  = r_dir  | in[i*DW_LINE + OFF_CTRL +: 2];
                end
            end
        end
    end

    assign is_add = seen_l & seen_r & (l_row == r_row);

`ifdef FAN_ADDER_SAT_EN
    logic [DW_DATA:0] sum_ext;
    always_comb begin
        sum_ext = {l_data[DW_DATA-1], l_data} + {r_data[DW_DATA-1], r_data};
        if (sum_ext[DW_DATA] != sum_ext[DW_DATA-1])
            s_data = sum_ext[DW_DATA] ? {1'b1, {(DW_DATA-1){1'b0}}} : {1'b0, {(DW_DATA-1){1'b1}}};
        else
            s_data = sum_ext[DW_DATA-1:0];
    end
`else
    always_comb s_data = l_data + r_data;
`endif

    always_comb begin
        res_on_right = 1'b0;
        res_code     = CTRL_PARTIAL;
        if (l_dir == DIR_LEFT && r_dir == DIR_RIGHT) begin
            res_code = CTRL_COMPLETE;
        end else if (l_dir == DIR_LEFT) begin
            res_code     = CTRL_FWD_RIGHT;
            res_on_right = 1'b1;
        end else if (r_dir == DIR_RIGHT) begin
            res_code = CTRL_FWD_LEFT;
        end else begin
            res_on_right = (SYMMETRY != 0);
        end
        res_line = {make_ctrl(res_code), l_row, s_data};
    end

    always_comb begin
        merged = in;
        if (is_add) begin
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                if (i == OUT_LEFT || i == OUT_RIGHT || !in[i*DW_LINE + OFF_K])
                    merged[i*DW_LINE +: DW_LINE] = '0;
            end
            if (res_on_right) merged[OUT_RIGHT*DW_LINE +: DW_LINE] = res_line;
            else              merged[OUT_LEFT*DW_LINE +: DW_LINE]  = res_line;
        end
    end

    assign in_ready = fifo_in_ready;
    assign accept   = in_valid & fifo_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            add_cnt <= '0;
            err     <= 1'b0;
        end else if (accept) begin
            if (is_add && add_cnt != '1) add_cnt <= add_cnt + CNT_W'(1);
            if (multi_l || multi_r)      err     <= 1'b1;
        end
    end

    fan_skid_fifo #(
        .WIDTH(W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (fifo_in_ready),
        .in       (merged),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out)
    );

endmodule

// File: tb/tb_fan_adder_node_pipe.sv
// Bench for fan_adder_node_pipe (NUM_IN=8, SYMMETRY=0): directed cases plus random traffic
// against an integer-arithmetic reference model and a queue of expected output beats.
module tb_fan_adder_node_pipe;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic [15:0]  add_cnt;
    logic         err;

    int n_checks = 0;
    int n_errors = 0;

    logic [127:0] q[$];
    int           m_cnt = 0;
    bit           m_err = 1'b0;

    always #5 clk = ~clk;

    fan_adder_node_pipe #(
        .DW_DATA (8),
        .DW_ROW  (4),
        .DW_CTRL (4),
        .NUM_IN  (8),
        .SYMMETRY(0),
        .CNT_W   (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in       (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out_data),
        .add_cnt  (add_cnt),
        .err      (err)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ln(input logic [3:0] c, input logic [3:0] r, input logic [7:0] d);
        return {c, r, d};
    endfunction

    // Reference: decode lanes into integers, pick operands, add, place the result.
    function automatic void model(input logic [127:0] x, output logic [127:0] y,
                                  output bit add, output bit multi);
        int nl = 0, nr = 0, ld = 0, rd = 0, lrow = 0, rrow = 0, ldir = 0, rdir = 0;
        int sl, sr, s, pos;
        logic [15:0] lane;
        logic [3:0]  code;
        for (int i = 0; i < 8; i++) begin
            lane = x[i*16 +: 16];
            if (lane[15]) begin
                if (i < 4) begin
                    nl++; ld |= int'(lane[7:0]); lrow |= int'(lane[11:8]); ldir |= int'(lane[13:12]);
                end else begin
                    nr++; rd |= int'(lane[7:0]); rrow |= int'(lane[11:8]); rdir |= int'(lane[13:12]);
                end
            end
        end
        multi = (nl > 1) || (nr > 1);
        add   = (nl > 0) && (nr > 0) && (lrow == rrow);
        if (!add) begin
            y = x;
            return;
        end
        sl = (ld >= 128) ? ld - 256 : ld;
        sr = (rd >= 128) ? rd - 256 : rd;
        s  = sl + sr;
`ifdef FAN_ADDER_SAT_EN
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
`endif
        if (ldir == 1 && rdir == 2) begin pos = 3; code = 4'b0111; end
        else if (ldir == 1)         begin pos = 4; code = 4'b1001; end
        else if (rdir == 2)         begin pos = 3; code = 4'b1010; end
        else                        begin pos = 3; code = 4'b1000; end
        y = '0;
        for (int i = 0; i < 8; i++) begin
            lane = x[i*16 +: 16];
            if (i != 3 && i != 4 && lane[14]) y[i*16 +: 16] = lane;
        end
        y[pos*16 +: 16] = {code, 4'(lrow), 8'(s)};
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_out_valid"}, 128'(out_valid), 128'(q.size() != 0));
        check({tag, "_out"},       out_data, (q.size() != 0) ? q[0] : 128'(0));
        check({tag, "_in_ready"},  128'(in_ready), 128'(q.size() < 2));
        check({tag, "_add_cnt"},   128'(add_cnt), 128'(m_cnt));
        check({tag, "_err"},       128'(err), 128'(m_err));
    endtask

    // Called at a negedge: drive, let one edge pass, update the model, check at the next negedge.
    task automatic cycle(input string tag, input bit v, input logic [127:0] d, input bit r);
        logic [127:0] y;
        bit add, multi, acc, pop;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        acc = v && (q.size() < 2);
        pop = (q.size() != 0) && r;
        if (pop) void'(q.pop_front());
        if (acc) begin
            model(d, y, add, multi);
            q.push_back(y);
            if (add && m_cnt < 65535) m_cnt++;
            if (multi) m_err = 1'b1;
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        @(posedge clk);
        q.delete();
        m_cnt = 0;
        m_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_outputs(tag);
        check({tag, "_in_ready_const"},  128'(in_ready), 128'(1));
        check({tag, "_out_valid_const"}, 128'(out_valid), 128'(0));
        check({tag, "_add_cnt_const"},   128'(add_cnt), 128'(0));
    endtask

    function automatic logic [127:0] pair(input int li, input logic [15:0] lv,
                                          input int ri, input logic [15:0] rv);
        logic [127:0] v = '0;
        v[li*16 +: 16] = lv;
        v[ri*16 +: 16] = rv;
        return v;
    endfunction

    initial begin
        logic [127:0] b, e;
        do_reset("reset");

        b = pair(1, ln(4'b1000, 4'd3, 8'd5), 6, ln(4'b1000, 4'd3, 8'd7));
        cycle("t1", 1'b1, b, 1'b1);
        e = '0; e[3*16 +: 16] = ln(4'b1000, 4'd3, 8'd12);
        check("t1_const_out", out_data, e);
        check("t1_const_cnt", 128'(add_cnt), 128'(1));

        b = pair(0, ln(4'b1001, 4'd2, 8'd4), 7, ln(4'b1010, 4'd2, 8'd9));
        cycle("t2", 1'b1, b, 1'b1);
        e = '0; e[3*16 +: 16] = ln(4'b0111, 4'd2, 8'd13);
        check("t2_const_complete", out_data, e);
        b = pair(0, ln(4'b1001, 4'd2, 8'd4), 7, ln(4'b1010, 4'd5, 8'd9));
        cycle("t2b", 1'b1, b, 1'b1);
        check("t2_const_bypass", out_data, b);
        check("t2_const_cnt", 128'(add_cnt), 128'(2));

        b = pair(1, ln(4'b1000, 4'd3, 8'd5), 6, ln(4'b1000, 4'd3, 8'd7));
        b[2*16 +: 16] = ln(4'b0100, 4'd1, 8'd3);
        b[5*16 +: 16] = ln(4'b0000, 4'd6, 8'd8);
        cycle("t3", 1'b1, b, 1'b1);
        e = '0; e[3*16 +: 16] = ln(4'b1000, 4'd3, 8'd12); e[2*16 +: 16] = ln(4'b0100, 4'd1, 8'd3);
        check("t3_const_keep", out_data, e);

        cycle("t4_drain", 1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            b = pair(1, ln(4'b1000, 4'd1, 8'(i + 1)), 6, ln(4'b1000, 4'd1, 8'd10));
            cycle("t4_fill", 1'b1, b, 1'b0);
        end
        check("t4_const_full", 128'(in_ready), 128'(0));
        for (int i = 0; i < 3; i++) cycle("t4_release", 1'b0, '0, 1'b1);

        b = pair(1, ln(4'b1000, 4'd0, 8'd120), 6, ln(4'b1000, 4'd0, 8'd100));
        cycle("t5a", 1'b1, b, 1'b1);
`ifdef FAN_ADDER_SAT_EN
        check("t5_const_pos", 128'(out_data[55:48]), 128'(8'd127));
`else
        check("t5_const_pos", 128'(out_data[55:48]), 128'(8'hDC));
`endif
        b = pair(1, ln(4'b1000, 4'd0, 8'd156), 6, ln(4'b1000, 4'd0, 8'd156));
        cycle("t5b", 1'b1, b, 1'b1);
`ifdef FAN_ADDER_SAT_EN
        check("t5_const_neg", 128'(out_data[55:48]), 128'(8'h80));
`else
        check("t5_const_neg", 128'(out_data[55:48]), 128'(8'd56));
`endif

        b = pair(0, ln(4'b1000, 4'd2, 8'd1), 1, ln(4'b1000, 4'd2, 8'd2));
        b[6*16 +: 16] = ln(4'b1000, 4'd2, 8'd3);
        cycle("t6", 1'b1, b, 1'b1);
        check("t6_const_err", 128'(err), 128'(1));
        for (int i = 0; i < 3; i++) cycle("t6_hold", 1'b0, '0, 1'b1);
        check("t6_const_sticky", 128'(err), 128'(1));
        do_reset("reset2");

        for (int n = 0; n < 400; n++) begin
            b = '0;
            for (int i = 0; i < 8; i++) begin
                b[i*16 +: 16] = ln({1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)), 2'($urandom)},
                                   4'($urandom_range(0, 1)), 8'($urandom));
            end
            cycle("rnd", 1'($urandom_range(0, 3) != 0), b, 1'($urandom_range(0, 2) != 0));
        end

        cycle("t6_drain", 1'b0, '0, 1'b1);
        cycle("t6_drain", 1'b0, '0, 1'b1);
        b = pair(1, ln(4'b1000, 4'd3, 8'd5), 6, ln(4'b1000, 4'd3, 8'd7));
        cycle("t6_fill", 1'b1, b, 1'b0);
        cycle("t6_fill", 1'b1, b, 1'b0);
        check("t6_const_two", 128'(in_ready), 128'(0));
        do_reset("reset3");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
